alavanca2serial: RTL and testbench

//  Transmit side of the lever serial link: packs two signed 16-bit lever values into a
//  6-byte UART packet (8N1) and shifts it out on TX. Sits on the controller/sensor side
//  (or the bench) and drives the RX pin consumed by the game datapath's lever decoder.

---
 rtl/alavanca2serial.sv | 151 +++++++++++++++
 tb/tb_alavanca2serial.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alavanca2serial.sv
// Lever serial transmitter: packs two signed 16-bit lever values into a 6-byte
// 8N1 UART packet (header, al1 hi/lo, al2 hi/lo, XOR checksum) and shifts it out on TX.
module alavanca2serial #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enviar,
    input  logic [15:0] al1Bits,
    input  logic [15:0] al2Bits,
    output logic        TX,
    output logic        ocupado,
    output logic        pronto,
    output logic [3:0]  db_estado
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        LOAD  = 4'd1,
        START = 4'd2,
        DATA  = 4'd3,
        STOP  = 4'd4,
        NEXT  = 4'd5,
        FIM   = 4'd6
    } state_t;

    state_t            state_reg, state_next;
    logic [BAUD_W-1:0] baud_reg, baud_next;
    logic [2:0]        bit_idx_reg, bit_idx_next;
    logic [2:0]        byte_idx_reg, byte_idx_next;
    logic [47:0]       shift_reg, shift_next;
    logic              tx_reg, tx_next;
    logic              ocupado_reg, ocupado_next;
    logic              pronto_reg, pronto_next;
    logic [7:0]        chk;
    logic              baud_tick;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_chk
            assign chk[gi] = al1Bits[gi + 8] ^ al1Bits[gi] ^ al2Bits[gi + 8] ^ al2Bits[gi];
        end
    endgenerate

    assign baud_tick = (baud_reg == BAUD_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            baud_reg     <= '0;
            bit_idx_reg  <= '0;
            byte_idx_reg <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
            ocupado_reg  <= 1'b0;
            pronto_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_idx_reg  <= bit_idx_next;
            byte_idx_reg <= byte_idx_next;
            shift_reg    <= shift_next;
            tx_reg       <= tx_next;
            ocupado_reg  <= ocupado_next;
            pronto_reg   <= pronto_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        baud_next     = '0;
        bit_idx_next  = bit_idx_reg;
        byte_idx_next = byte_idx_reg;
        shift_next    = shift_reg;
        case (state_reg)
            IDLE: begin
                if (enviar) state_next = LOAD;
            end
            LOAD: begin
                // Byte 0 sits in the low 8 bits; each DATA bit shifts right by one.
                shift_next    = {chk, al2Bits[7:0], al2Bits[15:8],
                                 al1Bits[7:0], al1Bits[15:8], HEADER};
                byte_idx_next = '0;
                bit_idx_next  = '0;
                state_next    = START;
            end
            START: begin
                baud_next = baud_reg + 1'b1;
                if (baud_tick) begin
                    baud_next  = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                baud_next = baud_reg + 1'b1;
                if (baud_tick) begin
                    baud_next  = '0;
                    shift_next = shift_reg >> 1;
                    if (bit_idx_reg == 3'd7) begin
                        bit_idx_next = '0;
                        state_next   = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            STOP: begin
                baud_next = baud_reg + 1'b1;
                if (baud_tick) begin
                    baud_next  = '0;
                    state_next = NEXT;
                end
            end
            NEXT: begin
                if (byte_idx_reg == 3'd5) begin
                    state_next = FIM;
                end else begin
                    byte_idx_next = byte_idx_reg + 3'd1;
                    state_next    = START;
                end
            end
            FIM: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the current state, so the line lags the FSM by one cycle.
    always_comb begin
        tx_next      = 1'b1;
        ocupado_next = (state_reg != IDLE);
        pronto_next  = (state_reg == FIM);
        if (state_reg == START) begin
            tx_next = 1'b0;
        end else if (state_reg == DATA) begin
            tx_next = shift_reg[0];
        end
    end

    assign TX        = tx_reg;
    assign ocupado   = ocupado_reg;
    assign pronto    = pronto_reg;
    assign db_estado = state_reg;

endmodule

// File: tb/tb_alavanca2serial.sv
// Testbench for alavanca2serial: scoreboard of expected bytes checked by a UART
// line monitor, plus latency, handshake, reset and bit-width checks.
module tb_alavanca2serial;

    localparam int CPB = 4;
    localparam int PKT_CYC = 6 * (10 * CPB + 1);

    logic        clk = 1'b0;
    logic        reset;
    logic        enviar;
    logic [15:0] al1;
    logic [15:0] al2;
    logic        tx;
    logic        ocupado;
    logic        pronto;
    logic [3:0]  db_estado;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    int  pronto_cnt = 0;
    int  rx_bytes   = 0;
    int  mon_cnt    = 0;
    bit  mon_busy   = 1'b0;
    logic [7:0] mon_byte = 8'h00;

    always #5 clk = ~clk;

    alavanca2serial #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
        .clock     (clk),
        .reset     (reset),
        .enviar    (enviar),
        .al1Bits   (al1),
        .al2Bits   (al2),
        .TX        (tx),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_pkt(input logic [15:0] a, input logic [15:0] b);
        exp_q.push_back(8'hA5);
        exp_q.push_back(a[15:8]);
        exp_q.push_back(a[7:0]);
        exp_q.push_back(b[15:8]);
        exp_q.push_back(b[7:0]);
        exp_q.push_back(a[15:8] ^ a[7:0] ^ b[15:8] ^ b[7:0]);
    endtask

    // Called at a negedge; returns at the negedge right after the sampling edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b);
        al1    = a;
        al2    = b;
        enviar = 1'b1;
        push_pkt(a, b);
        tick(1);
        enviar = 1'b0;
        $display("send al1=%04h al2=%04h", a, b);
    endtask

    task automatic wait_pronto(input int start, input int maxc, output int cyc);
        cyc = start;
        while (pronto !== 1'b1 && cyc < maxc) begin
            tick(1);
            cyc++;
        end
        if (pronto !== 1'b1) chk_eq("pronto_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_state(input logic [3:0] s, input int maxc);
        int c;
        c = 0;
        while (db_estado !== s && c < maxc) begin
            tick(1);
            c++;
        end
        if (db_estado !== s) chk_eq("state_timeout", db_estado, s);
    endtask

    // UART line monitor: decodes bytes mid-bit and checks them against the scoreboard.
    always @(negedge clk) begin
        if (pronto === 1'b1) pronto_cnt++;
        if (reset === 1'b1) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (tx === 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == 1) begin
                chk_eq("start_bit", tx, 1'b0);
            end else if (mon_cnt >= 5 && mon_cnt <= 33 && (mon_cnt % 4) == 1) begin
                mon_byte[(mon_cnt - 5) / 4] = tx;
            end else if (mon_cnt == 37) begin
                chk_eq("stop_bit", tx, 1'b1);
                if (exp_q.size() == 0) begin
                    chk_eq("unexpected_byte", mon_byte, 32'h1FF);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    $display("rx byte=%02h expected=%02h", mon_byte, e);
                    chk_eq("rx_byte", mon_byte, e);
                end
                rx_bytes++;
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int fims;
        int guard;
        int p0;
        int b0;
        bit stay_ok;
        logic exp_bits[$];
        logic obs_bits[$];
        int exp_runs[$];
        int obs_runs[$];
        logic [7:0] pkt[6];
        logic [15:0] a6;
        logic [15:0] b6;

        // 1: reset state and quiet idle
        reset = 1'b1; enviar = 1'b0; al1 = '0; al2 = '0;
        tick(3);
        chk_eq("rst_tx", tx, 1'b1);
        chk_eq("rst_ocupado", ocupado, 1'b0);
        chk_eq("rst_pronto", pronto, 1'b0);
        chk_eq("rst_state", db_estado, 4'd0);
        reset = 1'b0;
        stay_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (tx !== 1'b1 || db_estado !== 4'd0 || ocupado !== 1'b0 || pronto !== 1'b0) stay_ok = 1'b0;
        end
        chk_eq("idle_hold", stay_ok, 1'b1);

        // 2: basic packet, latency and handshake
        send(16'h1234, 16'hFF80);
        tick(1);
        chk_eq("lat_ocupado", ocupado, 1'b1);
        chk_eq("lat_tx_high", tx, 1'b1);
        tick(1);
        chk_eq("lat_tx_low", tx, 1'b0);
        wait_pronto(2, 2000, cyc);
        chk_eq("pronto_latency", cyc, 2 + PKT_CYC);
        chk_eq("fim_ocupado", ocupado, 1'b1);
        tick(1);
        chk_eq("pronto_pulse", pronto, 1'b0);
        chk_eq("ocupado_drop", ocupado, 1'b0);
        chk_eq("q_empty_t2", exp_q.size(), 0);
        chk_eq("pronto_cnt_t2", pronto_cnt, 1);

        // 3: inputs change mid-packet
        send(16'hFFFF, 16'h0000);
        tick(50);
        al1 = 16'h5A5A; al2 = 16'h1357;
        tick(30);
        al1 = $urandom_range(0, 65535); al2 = $urandom_range(0, 65535);
        wait_pronto(80, 2000, cyc);
        tick(2);
        chk_eq("q_empty_t3", exp_q.size(), 0);

        // 4: enviar held high -> back-to-back packets separated by IDLE+LOAD
        al1 = 16'h0102; al2 = 16'h0304;
        push_pkt(al1, al2);
        push_pkt(al1, al2);
        enviar = 1'b1;
        fims = 0; guard = 0;
        while (fims < 2 && guard < 2000) begin
            tick(1);
            guard++;
            if (db_estado === 4'd6) begin
                fims++;
                if (fims == 1) begin
                    tick(1); chk_eq("b2b_idle", db_estado, 4'd0);
                    tick(1); chk_eq("b2b_load", db_estado, 4'd1);
                    tick(1); chk_eq("b2b_start", db_estado, 4'd2);
                    guard += 3;
                end
            end
        end
        enviar = 1'b0;
        chk_eq("b2b_fims", fims, 2);
        tick(5);
        chk_eq("b2b_stop_idle", db_estado, 4'd0);
        chk_eq("q_empty_t4", exp_q.size(), 0);
        chk_eq("pronto_cnt_t4", pronto_cnt, 4);

        // 4b: enviar during DATA and during FIM is ignored
        send(16'h8001, 16'h7FFE);
        wait_state(4'd3, 100);
        enviar = 1'b1; tick(1); enviar = 1'b0;
        wait_state(4'd6, 2000);
        enviar = 1'b1; tick(1); enviar = 1'b0;
        tick(20);
        chk_eq("ignore_state", db_estado, 4'd0);
        chk_eq("ignore_ocupado", ocupado, 1'b0);
        chk_eq("ignore_pronto_cnt", pronto_cnt, 5);
        chk_eq("q_empty_t4b", exp_q.size(), 0);

        // 5: reset during byte 3 DATA drops the packet
        b0 = rx_bytes;
        send(16'hA1B2, 16'hC3D4);
        guard = 0;
        while (rx_bytes < b0 + 3 && guard < 2000) begin
            tick(1);
            guard++;
        end
        wait_state(4'd3, 100);
        tick(8);
        p0 = pronto_cnt;
        reset = 1'b1;
        tick(1);
        chk_eq("midrst_tx", tx, 1'b1);
        chk_eq("midrst_state", db_estado, 4'd0);
        chk_eq("midrst_pronto", pronto, 1'b0);
        tick(1);
        exp_q.delete();
        reset = 1'b0;
        tick(PKT_CYC);
        chk_eq("midrst_no_pronto", pronto_cnt, p0);
        send(16'h4321, 16'h8765);
        wait_pronto(0, 2000, cyc);
        chk_eq("post_rst_latency", cyc, 2 + PKT_CYC);
        tick(2);
        chk_eq("q_empty_t5", exp_q.size(), 0);

        // 5b: reset and enviar in the same cycle
        p0 = pronto_cnt;
        reset = 1'b1; enviar = 1'b1;
        tick(1);
        chk_eq("rst_en_state", db_estado, 4'd0);
        reset = 1'b0; enviar = 1'b0;
        tick(20);
        chk_eq("rst_en_tx", tx, 1'b1);
        chk_eq("rst_en_pronto", pronto_cnt, p0);

        // 6: bit widths against a line-level model
        a6 = 16'hA55A; b6 = 16'h0F3C;
        pkt[0] = 8'hA5; pkt[1] = a6[15:8]; pkt[2] = a6[7:0];
        pkt[3] = b6[15:8]; pkt[4] = b6[7:0];
        pkt[5] = pkt[1] ^ pkt[2] ^ pkt[3] ^ pkt[4];
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < CPB; j++) exp_bits.push_back(1'b0);
            for (int bi = 0; bi < 8; bi++)
                for (int j = 0; j < CPB; j++) exp_bits.push_back(pkt[k][bi]);
            for (int j = 0; j < ((k < 5) ? CPB + 1 : CPB); j++) exp_bits.push_back(1'b1);
        end
        send(a6, b6);
        guard = 0;
        while (tx !== 1'b0 && guard < 20) begin
            tick(1);
            guard++;
        end
        chk_eq("t6_start_seen", tx, 1'b0);
        for (int k = 0; k < exp_bits.size(); k++) begin
            obs_bits.push_back(tx);
            if (k < exp_bits.size() - 1) tick(1);
        end
        begin
            int run;
            run = 1;
            for (int k = 1; k < exp_bits.size(); k++) begin
                if (exp_bits[k] === exp_bits[k-1]) run++;
                else begin exp_runs.push_back(run); run = 1; end
            end
            exp_runs.push_back(run);
            run = 1;
            for (int k = 1; k < obs_bits.size(); k++) begin
                if (obs_bits[k] === obs_bits[k-1]) run++;
                else begin obs_runs.push_back(run); run = 1; end
            end
            obs_runs.push_back(run);
        end
        chk_eq("t6_run_count", obs_runs.size(), exp_runs.size());
        for (int k = 0; k < exp_runs.size() && k < obs_runs.size(); k++) begin
            chk_eq($sformatf("t6_run%0d", k), obs_runs[k], exp_runs[k]);
        end
        wait_pronto(0, 100, cyc);
        tick(2);
        chk_eq("q_empty_final", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
